// File: rtl/rsp_pkg.sv
// Shared definitions for mem_reader: default widths and FSM state encoding.
package rsp_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAP  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mem_reader.sv
// Burst memory reader: issues one read per word and holds each word until the consumer takes it.
// Build option MEM_READER_WRAP_EN lets a burst wrap past the top address instead of rejecting it.
module mem_reader
    import rsp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              mem_reader_clk,
    input  logic              mem_reader_rst,
    input  logic              mem_reader_start,
    input  logic [ADDR_W-1:0] mem_reader_base,
    input  logic [LEN_W-1:0]  mem_reader_len,
    output logic [ADDR_W-1:0] mem_reader_mem_addr,
    output logic              mem_reader_mem_rd_en,
    input  logic [DATA_W-1:0] mem_reader_mem_data,
    output logic [DATA_W-1:0] mem_reader_out_data,
    output logic              mem_reader_out_valid,
    input  logic              mem_reader_out_ready,
    output logic              mem_reader_busy,
    output logic              mem_reader_done,
    output logic              mem_reader_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              err_q;

    logic start_seen;
    logic start_bad;
    logic start_ok;
    logic accept;

`ifdef MEM_READER_WRAP_EN
    assign start_bad = 1'b0;
`else
    // One extra bit catches a burst that would run past the top address.
    logic [ADDR_W:0] end_addr;
    assign end_addr  = (ADDR_W+1)'(mem_reader_base) + (ADDR_W+1)'(mem_reader_len);
    assign start_bad = end_addr[ADDR_W];
`endif

    assign start_seen = (state_q == ST_IDLE) && mem_reader_start;
    assign start_ok   = start_seen && !start_bad;

    // Handshake: a word transfers at any rising edge where out_valid and out_ready are
    // both high; out_valid only rises in HOLD, so ready at other times is ignored.
    assign accept = (state_q == ST_HOLD) && mem_reader_out_ready;

    always_ff @(posedge mem_reader_clk) begin
        if (mem_reader_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_REQ;
            ST_REQ:  state_d = ST_CAP;
            ST_CAP:  state_d = ST_HOLD;
            ST_HOLD: if (accept) state_d = (cnt_q == '0) ? ST_DONE : ST_REQ;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_reader_mem_rd_en = (state_q == ST_REQ);
        mem_reader_mem_addr  = mem_reader_mem_rd_en ? addr_q : '0;
        mem_reader_busy      = (state_q != ST_IDLE);
        mem_reader_done      = (state_q == ST_DONE);
        mem_reader_out_data  = out_data_q;
        mem_reader_out_valid = out_valid_q;
        mem_reader_err       = err_q;
    end

    always_ff @(posedge mem_reader_clk) begin
        if (mem_reader_rst) begin
            addr_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= start_seen && start_bad;
            if (start_ok) begin
                addr_q <= mem_reader_base;
                cnt_q  <= mem_reader_len;
            end
            if (state_q == ST_CAP) begin
                out_data_q  <= mem_reader_mem_data;
                out_valid_q <= 1'b1;
            end
            if (accept) begin
                out_valid_q <= 1'b0;
                addr_q      <= addr_q + ADDR_W'(1);
                cnt_q       <= cnt_q - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: directed burst table, reset/ignore sequences, random bursts.
module tb_mem_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base;
    logic [3:0] len;
    logic [7:0] mem_addr;
    logic       rd_en;
    logic [7:0] mem_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] mem [256];
    logic [7:0] exp_q[$];
    logic [7:0] exp_addr_q[$];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] base;
        logic [3:0] len;
        int         mode;
        bit         busy_starts;
        bit         exp_err_nowrap;
    } vec_t;

    vec_t vecs[8];

    mem_reader dut (
        .mem_reader_clk      (clk),
        .mem_reader_rst      (rst),
        .mem_reader_start    (start),
        .mem_reader_base     (base),
        .mem_reader_len      (len),
        .mem_reader_mem_addr (mem_addr),
        .mem_reader_mem_rd_en(rd_en),
        .mem_reader_mem_data (mem_data),
        .mem_reader_out_data (out_data),
        .mem_reader_out_valid(out_valid),
        .mem_reader_out_ready(ready),
        .mem_reader_busy     (busy),
        .mem_reader_done     (done),
        .mem_reader_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) mem_data <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [7:0] b, input logic [3:0] l);
`ifdef MEM_READER_WRAP_EN
        return 1'b0;
`else
        return (int'(b) + int'(l)) > 255;
`endif
    endfunction

    task automatic check_idle_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_rd_en", rd_en, 0);
            check("idle_done", done, 0);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low for 5 valid cycles of word 0
    task automatic run_burst(input logic [7:0] b, input logic [3:0] l, input int mode,
                             input bit busy_starts, input bit exp_err);
        int k;
        bit fin;
        int nrd;
        int word;
        int kdone;
        kdone = 3 * (int'(l) + 1);
        exp_q.delete();
        exp_addr_q.delete();
        if (!exp_err) begin
            for (int i = 0; i <= int'(l); i++) begin
                logic [7:0] a;
                a = b + 8'(i);
                exp_addr_q.push_back(a);
                exp_q.push_back(mem[a]);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l; ready = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        if (exp_err) begin
            @(negedge clk);
            check("err_pulse", err, 1);
            check("err_busy", busy, 0);
            check("err_rd_en", rd_en, 0);
            @(negedge clk);
            check("err_single", err, 0);
            check("err_busy2", busy, 0);
            check("err_rd_en2", rd_en, 0);
            return;
        end
        k = 0; fin = 1'b0; nrd = 0; word = 0;
        while (!fin && k < 400) begin
            @(negedge clk);
            if (mode == 0) begin
                check("rd_en_timing", rd_en, (k % 3 == 0) && (k <= 3 * int'(l)));
                check("valid_timing", out_valid, (k % 3 == 2) && (k <= 3 * int'(l) + 2));
                check("done_timing", done, k == kdone);
            end
            check("busy_in_burst", busy, 1);
            check("no_err", err, 0);
            if (rd_en) begin
                nrd++;
                check("read_while_held", out_valid, 0);
                if (exp_addr_q.size() == 0) check("extra_read", nrd, int'(l) + 1);
                else check("rd_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (out_valid) begin
                if (exp_q.size() == 0) check("extra_word", word, int'(l) + 1);
                else begin
                    check("out_data", out_data, exp_q[0]);
                    if (ready) begin
                        void'(exp_q.pop_front());
                        word++;
                    end
                end
            end
            if (done) begin
                fin = 1'b1;
                check("words_at_done", word, int'(l) + 1);
                check("reads_at_done", nrd, int'(l) + 1);
            end
            @(posedge clk); #1;
            k++;
            if (mode == 0) ready = 1'b1;
            else if (mode == 1) ready = 1'($urandom_range(0, 1));
            else ready = !(word == 0 && k < 7);
            start = busy_starts && !fin && (k % 2 == 1);
            base = 8'($urandom);
            len = 4'($urandom);
        end
        start = 1'b0;
        if (!fin) check("burst_timeout", 0, 1);
        check_idle_quiet(3);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA5;

        vecs[0] = '{8'h10, 4'd0,  0, 1'b0, 1'b0};
        vecs[1] = '{8'h20, 4'd3,  0, 1'b0, 1'b0};
        vecs[2] = '{8'h40, 4'd1,  2, 1'b0, 1'b0};
        vecs[3] = '{8'hFE, 4'd3,  0, 1'b0, 1'b1};
        vecs[4] = '{8'h30, 4'd2,  0, 1'b1, 1'b0};
        vecs[5] = '{8'hF0, 4'd15, 1, 1'b0, 1'b0};
        vecs[6] = '{8'hF1, 4'd15, 0, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 4'd15, 0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; base = '0; len = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            bit e;
`ifdef MEM_READER_WRAP_EN
            e = 1'b0;
`else
            e = vecs[v].exp_err_nowrap;
`endif
            run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].busy_starts, e);
        end

        // Reset while word 1 of a four-word burst is being held.
        @(posedge clk); #1;
        start = 1'b1; base = 8'h60; len = 4'd3; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("hold_w1_valid", out_valid, 1);
        check("hold_w1_data", out_data, mem[8'h61]);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check_idle_quiet(4);
        run_burst(8'h60, 4'd3, 0, 1'b0, 1'b0);

        for (int n = 0; n < 15; n++) begin
            logic [7:0] rb;
            logic [3:0] rl;
            rb = 8'($urandom_range(0, 255));
            rl = 4'($urandom_range(0, 15));
            run_burst(rb, rl, 1, 1'b0, model_err(rb, rl));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8: memory address width.
REQ-002 The module SHALL have parameter DATA_W, default 8: memory and output data width.
REQ-003 The module SHALL have parameter LEN_W, default 4: burst length field width; burst size is len+1 words (1..16).
REQ-004 The module SHALL have port mem_reader_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port mem_reader_rst  input  1  reset, synchronous and active-high.
REQ-006 The module SHALL have port mem_reader_start  input  1  burst request, sampled only in IDLE.
REQ-007 The module SHALL have port mem_reader_base  input  ADDR_W  burst start address, sampled with start.
REQ-008 The module SHALL have port mem_reader_len  input  LEN_W  burst size minus one, sampled with start.
REQ-009 The module SHALL have port mem_reader_mem_addr  output  ADDR_W  memory read address.
REQ-010 The module SHALL have port mem_reader_mem_rd_en  output  1  memory read strobe; data is returned one cycle later.
REQ-011 The module SHALL have port mem_reader_mem_data  input  DATA_W  memory read data, valid in the cycle after rd_en.
REQ-012 The module SHALL have port mem_reader_out_data  output  DATA_W  word presented to the consumer.
REQ-013 The module SHALL have port mem_reader_out_valid  output  1  out_data is valid.
REQ-014 The module SHALL have port mem_reader_out_ready  input  1  consumer accepts out_data.
REQ-015 The module SHALL have port mem_reader_busy  output  1  high in every state except IDLE.
REQ-016 The module SHALL have port mem_reader_done  output  1  one-cycle pulse after the last word is accepted.
REQ-017 The module SHALL have port mem_reader_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, CAP, HOLD and DONE.
REQ-019 On an edge in IDLE with start=1 and the request accepted, the FSM SHALL latch base and len and enter REQ.
REQ-020 In REQ, the block SHALL drive rd_en=1 and mem_addr=current address, then enter CAP at the next edge.
REQ-021 In CAP, the block SHALL register mem_data into out_data, set out_valid=1 at that edge and enter HOLD.
REQ-022 In HOLD, out_data and out_valid SHALL stay stable until an edge with out_ready=1.
REQ-023 At an accepting edge in HOLD, the block SHALL clear out_valid, increment the address, decrement the remaining count, and enter REQ if words remain, else DONE.
REQ-024 The block SHALL achieve a throughput of one word per 3 cycles under constant ready, with first-word latency of 2 cycles from the start edge to out_valid.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a start seen in DONE SHALL be ignored.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 rd_en SHALL be 0 outside REQ; at most one read SHALL be in flight.
REQ-028 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-029 Reset SHALL take priority over all other inputs at the same edge and force IDLE.
REQ-030 On reset, every output SHALL be 0: mem_addr, rd_en, out_data, out_valid, busy, done and err.
REQ-031 Reset mid-burst SHALL abandon the burst with no done pulse; any held word SHALL be dropped.

Configuration
REQ-032 With macro MEM_READER_WRAP_EN defined, the address SHALL wrap from 2^ADDR_W-1 to 0 within a burst, and err SHALL never assert.
REQ-033 Without MEM_READER_WRAP_EN, a start with base+len > 2^ADDR_W-1 SHALL be rejected: err=1 for one cycle after the start edge, no read is issued, and the FSM stays IDLE.

Structure
REQ-034 The FSM state encoding and default widths SHALL live in the shared package rsp_pkg.
REQ-035 The block SHALL be implemented as a single module with no sub-module; the output holding register is inline.

Verification
REQ-036 Bench SHALL cover: base=0x10, len=0, ready=1, mem[0x10]=0xA5 -> one rd_en at 0x10; out_valid with 0xA5 two cycles after start; done pulse 3 cycles after start.
REQ-037 Bench SHALL cover: base=0x20, len=3, ready=1 -> reads 0x20..0x23 in order, 4 words delivered 3 cycles apart, a single done pulse.
REQ-038 Bench SHALL cover: base=0x40, len=1, ready low for 5 cycles on word 0 -> out_data held stable; no second rd_en until acceptance.
REQ-039 Bench SHALL cover: base=0xFE, len=3 -> with WRAP_EN, reads 0xFE, 0xFF, 0x00, 0x01; without WRAP_EN, err pulse, no rd_en, busy=0.
REQ-040 Bench SHALL cover: reset asserted in HOLD of word 1 of len=3 -> next cycle all outputs 0, no done; a fresh start then behaves normally.
REQ-041 Bench SHALL cover: start pulsed while busy and in DONE -> ignored; the burst count and addresses are unchanged.
